// File: rtl/abc_sweep_pkg.sv
// Shared types and constants for the A/B/C truth-table sweep stages.
// The golden table is F = A(B+C) indexed by {A,B,C}.
package abc_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_t;

  localparam int VEC_W   = 3;
  localparam int NUM_VEC = 8;

  localparam logic [NUM_VEC-1:0] F_GOLDEN = 8'hE0;

  // Bit i set where the recorded sample disagrees with the golden table.
  function automatic logic [NUM_VEC-1:0] table_diff(
    input logic [NUM_VEC-1:0] recorded,
    input logic [NUM_VEC-1:0] golden
  );
    return recorded ^ golden;
  endfunction

endpackage

// File: rtl/abc_settle_timer.sv
// Settle counter: counts enabled cycles and flags the cycle on which the
// count equals LAST_COUNT, wrapping to zero on that same edge.
module abc_settle_timer #(
  parameter int unsigned LAST_COUNT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam logic [3:0] LAST_C = 4'(LAST_COUNT);

  logic [3:0] count_r;
  logic       at_last_s;

  assign at_last_s = (count_r == LAST_C);
  assign last      = enable & at_last_s;

  // Count register: clear dominates, wraps after the last settle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 4'd0;
    end else if (clear) begin
      count_r <= 4'd0;
    end else if (enable) begin
      if (at_last_s) begin
        count_r <= 4'd0;
      end else begin
        count_r <= count_r + 4'd1;
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/abc_sweep_recorder.sv
// Sweeps {A,B,C} through all eight vectors, records F per vector and
// compares the recorded truth table against EXPECTED_F.
module abc_sweep_recorder
  import abc_sweep_pkg::*;
#(
  parameter int unsigned        SETTLE_CYCLES = 2,
  parameter logic [NUM_VEC-1:0] EXPECTED_F    = F_GOLDEN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               a_o,
  output logic               b_o,
  output logic               c_o,
  input  logic               f_i,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [NUM_VEC-1:0] result,
  output logic [NUM_VEC-1:0] mismatch
);

  localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(NUM_VEC - 1);

  sweep_state_t       state_r, state_nxt_s;
  logic [VEC_W-1:0]   index_r, index_nxt_s;
  logic [VEC_W-1:0]   abc_r, abc_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic               done_r, done_nxt_s;
  logic               pass_r, pass_nxt_s;
  logic [NUM_VEC-1:0] result_r, result_nxt_s;
  logic [NUM_VEC-1:0] mismatch_r, mismatch_nxt_s;
  logic               tmr_clear_s;
  logic               tmr_en_s;
  logic               tmr_last_s;

  abc_settle_timer #(
    .LAST_COUNT (SETTLE_CYCLES - 1)
  ) u_settle (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear_s),
    .enable (tmr_en_s),
    .last   (tmr_last_s)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt_s    = state_r;
    index_nxt_s    = index_r;
    abc_nxt_s      = abc_r;
    busy_nxt_s     = busy_r;
    done_nxt_s     = 1'b0;
    pass_nxt_s     = pass_r;
    result_nxt_s   = result_r;
    mismatch_nxt_s = mismatch_r;
    tmr_clear_s    = 1'b1;
    tmr_en_s       = 1'b0;

    case (state_r)
      IDLE: begin
        abc_nxt_s  = {VEC_W{1'b0}};
        busy_nxt_s = 1'b0;
        if (start) begin
          state_nxt_s    = RUN;
          index_nxt_s    = {VEC_W{1'b0}};
          busy_nxt_s     = 1'b1;
          pass_nxt_s     = 1'b0;
          result_nxt_s   = {NUM_VEC{1'b0}};
          mismatch_nxt_s = {NUM_VEC{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end

      RUN: begin
        tmr_clear_s = 1'b0;
        tmr_en_s    = 1'b1;
        if (abort) begin
          // Partial result stays visible; verdict outputs are left cleared.
          state_nxt_s = IDLE;
          index_nxt_s = {VEC_W{1'b0}};
          abc_nxt_s   = {VEC_W{1'b0}};
          busy_nxt_s  = 1'b0;
          tmr_clear_s = 1'b1;
          tmr_en_s    = 1'b0;
        end else if (tmr_last_s) begin
          result_nxt_s[index_r] = f_i;
          if (index_r == LAST_IDX) begin
            state_nxt_s    = DONE;
            abc_nxt_s      = {VEC_W{1'b0}};
            busy_nxt_s     = 1'b0;
            done_nxt_s     = 1'b1;
            pass_nxt_s     = (result_nxt_s == EXPECTED_F);
            mismatch_nxt_s = table_diff(result_nxt_s, EXPECTED_F);
          end else begin
            index_nxt_s = index_r + 3'd1;
            abc_nxt_s   = index_r + 3'd1;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end

      DONE: begin
        state_nxt_s = IDLE;
        abc_nxt_s   = {VEC_W{1'b0}};
        busy_nxt_s  = 1'b0;
      end

      default: begin
        state_nxt_s = IDLE;
        index_nxt_s = {VEC_W{1'b0}};
        abc_nxt_s   = {VEC_W{1'b0}};
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      index_r    <= {VEC_W{1'b0}};
      abc_r      <= {VEC_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      result_r   <= {NUM_VEC{1'b0}};
      mismatch_r <= {NUM_VEC{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      index_r    <= index_nxt_s;
      abc_r      <= abc_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
      pass_r     <= pass_nxt_s;
      result_r   <= result_nxt_s;
      mismatch_r <= mismatch_nxt_s;
    end
  end

  assign a_o      = abc_r[2];
  assign b_o      = abc_r[1];
  assign c_o      = abc_r[0];
  assign busy     = busy_r;
  assign done     = done_r;
  assign pass     = pass_r;
  assign result   = result_r;
  assign mismatch = mismatch_r;

endmodule

// File: tb/tb_abc_sweep_recorder.sv
// Directed bench for abc_sweep_recorder: table of full sweeps against
// several gate models, plus abort, stray-start, reset and 1-cycle settle.
module tb_abc_sweep_recorder;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, f, start1;
  logic       a, b, c, busy, done, pass;
  logic [7:0] result, mismatch;
  logic       a1, b1, c1, busy1, done1, pass1, f1;
  logic [7:0] result1, mismatch1;
  int         mode;
  int         passed = 0;
  int         total  = 0;

  always #5 clk = ~clk;

  // Gate models: 0 golden A(B+C), 1 stuck-0, 2 stuck-1, 3 faulty A&B.
  always_comb begin
    case (mode)
      0: f = a & (b | c);
      1: f = 1'b0;
      2: f = 1'b1;
      3: f = a & b;
      default: f = 1'b0;
    endcase
  end
  assign f1 = a1 & (b1 | c1);

  abc_sweep_recorder #(.SETTLE_CYCLES(2), .EXPECTED_F(8'hE0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a_o(a), .b_o(b), .c_o(c), .f_i(f),
    .busy(busy), .done(done), .pass(pass), .result(result), .mismatch(mismatch)
  );

  abc_sweep_recorder #(.SETTLE_CYCLES(1), .EXPECTED_F(8'hE0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0),
    .a_o(a1), .b_o(b1), .c_o(c1), .f_i(f1),
    .busy(busy1), .done(done1), .pass(pass1), .result(result1), .mismatch(mismatch1)
  );

  typedef struct {
    int         mode;
    logic [7:0] exp_result;
    logic [7:0] exp_mis;
    logic       exp_pass;
    int         stray_cyc;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle c0 of a sweep; returns the cycle in which done is seen.
  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (!done && cyc <= 40) begin
      step();
      cyc++;
    end
  endtask

  task automatic sweep(input vec_t v);
    int       cyc;
    int       bad;
    logic [2:0] exp_abc;
    mode  = v.mode;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    bad = 0;
    while (!done && cyc <= 40) begin
      exp_abc = 3'((cyc - 1) / 2);
      if ({a, b, c} !== exp_abc || busy !== 1'b1) bad++;
      start = (cyc == v.stray_cyc);
      step();
      cyc++;
    end
    start = 1'b0;
    chk("hold_seq_errors", bad, 0);
    chk("done_cycle", cyc, 17);
    chk("result", result, v.exp_result);
    chk("mismatch", mismatch, v.exp_mis);
    chk("pass", pass, v.exp_pass);
    chk("busy_in_done", busy, 1'b0);
    step();
    chk("done_one_cycle", done, 1'b0);
    chk("pass_held", pass, v.exp_pass);
    chk("idle_busy", busy, 1'b0);
  endtask

  initial begin
    int cyc;
    int ndone;

    vecs[0] = '{0, 8'hE0, 8'h00, 1'b1, 0};
    vecs[1] = '{1, 8'h00, 8'hE0, 1'b0, 0};
    vecs[2] = '{2, 8'hFF, 8'h1F, 1'b0, 0};
    vecs[3] = '{3, 8'hC0, 8'h20, 1'b0, 5};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start1 = 1'b0; mode = 0;
    #12;
    chk("reset_ctrl", {a, b, c, busy, done, pass}, 6'b0);
    chk("reset_result", result, 8'h00);
    chk("reset_mismatch", mismatch, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++) sweep(vecs[i]);

    // start during DONE is ignored; start the cycle after DONE runs a new sweep
    mode = 0; start = 1'b1; step(); start = 1'b0;
    wait_done(1, cyc);
    chk("seq_done_cycle", cyc, 17);
    start = 1'b1; step();
    chk("start_in_done_ignored", busy, 1'b0);
    step(); start = 1'b0;
    chk("restart_busy", busy, 1'b1);
    chk("restart_clears_result", result, 8'h00);
    chk("restart_clears_pass", pass, 1'b0);
    wait_done(1, cyc);
    chk("restart_done_cycle", cyc, 17);
    chk("restart_result", result, 8'hE0);

    // abort while index = 3
    step();
    mode = 2; start = 1'b1; step(); start = 1'b0;
    for (int i = 1; i < 7; i++) step();
    chk("abort_idx3", {a, b, c}, 3'd3);
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_abc", {a, b, c}, 3'd0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_result", result, 8'h07);
    chk("abort_pass", pass, 1'b0);
    chk("abort_mismatch", mismatch, 8'h00);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) ndone++;
      step();
    end
    chk("abort_no_done", ndone, 0);

    // start and abort together in IDLE: start wins
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    chk("start_beats_abort", busy, 1'b1);
    wait_done(1, cyc);
    chk("sa_done_cycle", cyc, 17);
    chk("sa_result", result, 8'hFF);
    step();

    // asynchronous reset mid-sweep
    mode = 2; start = 1'b1; step(); start = 1'b0;
    for (int i = 1; i < 9; i++) step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {a, b, c, busy, done, pass}, 6'b0);
    chk("midrst_result", result, 8'h00);
    chk("midrst_mismatch", mismatch, 8'h00);
    @(posedge clk); #1;
    chk("midrst_no_done", done, 1'b0);
    rst_n = 1'b1;
    step();
    sweep(vecs[0]);

    // SETTLE_CYCLES = 1 instance
    start1 = 1'b1; step(); start1 = 1'b0;
    cyc = 1;
    while (!done1 && cyc <= 40) begin
      step();
      cyc++;
    end
    chk("s1_done_cycle", cyc, 9);
    chk("s1_result", result1, 8'hE0);
    chk("s1_pass", pass1, 1'b1);
    chk("s1_mismatch", mismatch1, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/abc_sweep_recorder.md
Name: abc_sweep_recorder

Overview:
- Drives the three inputs A, B, C of the downstream F = A(B+C) gate stage through all 8 combinations and samples F for each.
- Records the resulting truth table in an 8-bit register and compares it against the golden table.
- Reports pass/fail through a start/busy/done handshake.
- Turns the combinational lab circuit into a self-recording, self-checking test stage.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before F is sampled; legal range 1..15.
- EXPECTED_F, 8'hE0, golden truth table; bit i is F for {A,B,C} = i.

Ports:
- clk  input  1  single system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- abort  input  1  cancel a sweep in progress.
- a_o  output  1  drives A of the gate stage.
- b_o  output  1  drives B of the gate stage.
- c_o  output  1  drives C of the gate stage.
- f_i  input  1  F returned from the gate stage; synchronous to clk.
- busy  output  1  high while a sweep runs.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  result == EXPECTED_F; valid from done, held until the next accepted start.
- result  output  8  recorded truth table; bit i is the sample taken for vector i.
- mismatch  output  8  result XOR EXPECTED_F; updated together with pass.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; a_o, b_o, c_o, busy, done, pass = 0; result = 0; mismatch = 0; vector index = 0; settle count = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - {a_o,b_o,c_o} = 3'b000; busy = 0.
  - start=1 moves to RUN with index=0 and settle count=0.
  - The same start clears result, mismatch and pass.
- RUN:
  - busy = 1; {a_o,b_o,c_o} = index, registered.
  - The settle count increments every cycle.
  - When the count reaches SETTLE_CYCLES-1, f_i is written into result[index] on that edge and the count returns to 0.
  - If index==7, go to DONE; otherwise index increments.
  - Each vector is therefore held for exactly SETTLE_CYCLES cycles.
- DONE:
  - Lasts one cycle; done=1, busy=0.
  - pass and mismatch are registered from the complete result on the edge entering DONE, so they are valid in the same cycle as done.
  - Returns to IDLE unconditionally.
- Latency: start is sampled high at edge 0. RUN occupies 8*SETTLE_CYCLES cycles, so done is high in cycle 8*SETTLE_CYCLES+1 (cycle 17 for the default).
- start while busy, or during DONE: ignored; a sweep needs a fresh start in IDLE.
- abort in RUN:
  - Next state is IDLE; {a_o,b_o,c_o} returns to 0; no done pulse.
  - The partial result stays visible; pass stays 0 and mismatch stays 0.
- abort in IDLE or DONE: no effect.
- abort and start together in IDLE: start wins, because abort only acts in RUN.
- Reset mid-sweep: immediate return to reset values with no done pulse.
- Index arithmetic: 3-bit counter; no wrap beyond 7, because the DONE transition occurs at 7.
- SETTLE_CYCLES=1 is legal: one sample per cycle, done in cycle 9.

Decomposition:
- Package abc_sweep_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - VEC_W = 3 and NUM_VEC = 8;
  - the default golden constant F_GOLDEN = 8'hE0.
- Sub-module abc_settle_timer: a 4-bit settle counter with clear/enable inputs and a 'last' output, reused by future sweep stages.

Test Plan:
- Golden gate model on f_i, SETTLE_CYCLES=2, start pulse at cycle 0 -> vectors 0..7 each held 2 cycles; done in cycle 17; result=8'hE0; pass=1; mismatch=8'h00.
- f_i tied to 0 -> result=8'h00, mismatch=8'hE0, pass=0. f_i tied to 1 -> result=8'hFF, mismatch=8'h1F, pass=0.
- Faulty model F=A&B -> result=8'hC0, mismatch=8'h20, pass=0.
- Abort while index=3 -> IDLE the next cycle; outputs 000; busy=0; no done; result[2:0] recorded and result[7:3]=0.
- start pulses during RUN and during the DONE cycle -> ignored, exactly one done. A start the cycle after DONE -> a new sweep that clears result.
- rst_n asserted mid-sweep (asynchronous, between edges) -> all outputs 0 immediately. After release, start -> a normal sweep with pass=1.
